// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types and constants for the Needleman-Wunsch job controller
package nw_pkg;

    // Controller sequencing: accept a job, clear the grid, run it, hand back the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } nw_ctrl_state_t;

    // Traceback direction codes used by the grid cells.
    localparam logic [1:0] TOP    = 2'b00;
    localparam logic [1:0] LEFT   = 2'b01;
    localparam logic [1:0] CORNER = 2'b10;

    // Default scoring weights.
    localparam int MATCH    = 1;
    localparam int INDEL    = -1;
    localparam int MISMATCH = -1;

endpackage

// File: rtl/nw_rr_arbiter.sv
// rtl/nw_rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req    : pending requests, one bit per requester
//   ptr    : highest-priority requester for this evaluation
//   grant  : one-hot grant, zero when no request is pending
//   gnt_id : index of the granted requester (0 when none)
module nw_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id
);

    logic found;
    int   idx;

    // Scan from ptr upward, wrapping, and stop at the first pending request.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/nw_job_ctrl.sv
// rtl/nw_job_ctrl.sv - shares one NW grid between NREQ requesters
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/req_ready    : per-requester job handshake (ready is one-hot, IDLE only)
//   req_s1, req_s2         : packed per-requester string pairs
//   grid_s1, grid_s2       : latched strings of the job in flight
//   grid_reset             : grid clear strobe (held during reset and CLEAR)
//   grid_score, grid_valid : grid result and its level-valid
//   rsp_*                  : response channel (id, score, timeout flag)
//   busy                   : a job is in flight
module nw_job_ctrl
    import nw_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int LENGTH     = 10,
    parameter  int CWIDTH     = 2,
    parameter  int SWIDTH     = 16,
    parameter  int CLR_CYCLES = 2,
    parameter  int TIMEOUT    = 1024,
    localparam int IDW        = $clog2(NREQ),
    localparam int SW         = LENGTH * CWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*SW-1:0]       req_s1,
    input  logic [NREQ*SW-1:0]       req_s2,
    output logic [SW-1:0]            grid_s1,
    output logic [SW-1:0]            grid_s2,
    output logic                     grid_reset,
    input  logic signed [SWIDTH-1:0] grid_score,
    input  logic                     grid_valid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic signed [SWIDTH-1:0] rsp_score,
    output logic                     rsp_timeout,
    output logic                     busy
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    nw_ctrl_state_t  state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q;
    logic [CNTW-1:0] cnt_q;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            transfer;
    logic            clr_done;
    logic            run_expired;

    nw_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign transfer    = |(req_valid & req_ready);
    assign clr_done    = (cnt_q == CNTW'(CLR_CYCLES - 1));
    assign run_expired = (cnt_q == CNTW'(TIMEOUT - 1));
    assign grid_reset  = reset | (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = reset ? '0 : grant;
                if (transfer) state_d = CLEAR;
            end
            CLEAR: if (clr_done) state_d = RUN;
            // grid_valid takes precedence: it and expiry both lead to RESP,
            // the result capture below decides which outcome is reported.
            RUN:   if (grid_valid || run_expired) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            grid_s1     <= '0;
            grid_s2     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_score   <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= (state_d == RESP);
            busy      <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        grid_s1  <= req_s1[gnt_id*SW +: SW];
                        grid_s2  <= req_s2[gnt_id*SW +: SW];
                        rsp_id   <= gnt_id;
                        rr_ptr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                        cnt_q    <= '0;
                    end
                end
                CLEAR: cnt_q <= clr_done ? '0 : cnt_q + 1'b1;
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (grid_valid) begin
                        rsp_score   <= grid_score;
                        rsp_timeout <= 1'b0;
                    end else if (run_expired) begin
                        rsp_score   <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_ctrl.sv
// tb/tb_nw_job_ctrl.sv - randomized self-checking bench for nw_job_ctrl
module tb_nw_job_ctrl;

    localparam int NREQ = 4;
    localparam int LENGTH = 10;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int CLR = 2;
    localparam int TO = 16;
    localparam int SW = LENGTH * CWIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*SW-1:0] req_s1, req_s2;
    logic [SW-1:0]     grid_s1, grid_s2;
    logic              grid_reset;
    logic [SWIDTH-1:0] grid_score;
    logic              grid_valid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [SWIDTH-1:0] rsp_score;
    logic              rsp_timeout;
    logic              busy;

    nw_job_ctrl #(
        .NREQ(NREQ), .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
        .CLR_CYCLES(CLR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2),
        .grid_s1(grid_s1), .grid_s2(grid_s2), .grid_reset(grid_reset),
        .grid_score(grid_score), .grid_valid(grid_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_score(rsp_score), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side model: pending flags, current strings, round-robin pointer.
    logic [NREQ-1:0] pend;
    logic [SW-1:0]   s1m [NREQ];
    logic [SW-1:0]   s2m [NREQ];
    int              rr_m = 0;

    // Grid stand-in: result appears gk cycles after the clear strobe drops;
    // optionally shows a bogus valid while being cleared.
    int gcnt = 0;
    int gk = 1000;
    bit glitch = 1'b0;

    function automatic logic [15:0] score_fn(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return a[15:0] + {b[3:0], b[19:8]};
    endfunction

    always @(posedge clk) begin
        if (grid_reset) gcnt <= 0;
        else            gcnt <= gcnt + 1;
    end

    assign grid_valid = grid_reset ? glitch : (gcnt >= gk);
    assign grid_score = grid_reset ? 16'h7fff : score_fn(grid_s1, grid_s2);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_s1[i*SW +: SW] = s1m[i];
            req_s2[i*SW +: SW] = s2m[i];
        end
    endtask

    // Runs one job end to end, starting just after a falling edge with the DUT idle.
    task automatic do_job(input int k, input bit gl, input int hold, input bit refill);
        int exp_id, keff, lat, n;
        bit exp_to;
        logic [15:0] exp_sc;
        logic [SW-1:0] o1, o2;
        logic [31:0] one;
        if (pend == '0) pend[$urandom_range(0, NREQ-1)] = 1'b1;
        gk = k;
        glitch = gl;
        rsp_ready = 1'b0;
        drive_reqs();
        #1;
        exp_id = -1;
        for (int j = 0; j < NREQ; j++)
            if (exp_id < 0 && pend[(rr_m + j) % NREQ]) exp_id = (rr_m + j) % NREQ;
        one = 32'd1;
        check_eq("grant", 32'(req_ready), one << exp_id);
        o1 = s1m[exp_id];
        o2 = s2m[exp_id];
        exp_to = (k > TO - 1);
        keff = exp_to ? TO - 1 : k;
        lat = CLR + keff + 2;
        exp_sc = exp_to ? 16'd0 : score_fn(o1, o2);
        rr_m = (exp_id + 1) % NREQ;
        @(negedge clk);
        s1m[exp_id] = SW'($urandom);
        s2m[exp_id] = SW'($urandom);
        pend[exp_id] = refill ? 1'b1 : 1'($urandom_range(0, 1));
        drive_reqs();
        n = 1;
        while (n <= 60) begin
            #1;
            if (rsp_valid) break;
            check_eq("grid_reset", 32'(grid_reset), 32'(n <= CLR));
            check_eq("ready_busy", 32'(req_ready), 32'd0);
            check_eq("busy", 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        check_eq("latency", n, lat);
        check_eq("rsp_id", 32'(rsp_id), exp_id);
        check_eq("rsp_score", 32'(rsp_score), 32'(exp_sc));
        check_eq("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        check_eq("grid_s1", 32'(grid_s1), 32'(o1));
        check_eq("grid_s2", 32'(grid_s2), 32'(o2));
        check_eq("grid_reset_resp", 32'(grid_reset), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_id", 32'(rsp_id), exp_id);
            check_eq("hold_score", 32'(rsp_score), 32'(exp_sc));
            check_eq("hold_timeout", 32'(rsp_timeout), 32'(exp_to));
            check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check_eq("rsp_done", 32'(rsp_valid), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        int kk;
        reset = 1'b1;
        rsp_ready = 1'b0;
        pend = '1;
        for (int i = 0; i < NREQ; i++) begin
            s1m[i] = SW'($urandom);
            s2m[i] = SW'($urandom);
        end
        drive_reqs();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grid_reset", 32'(grid_reset), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_grid_s1", 32'(grid_s1), 32'd0);
        check_eq("rst_rsp_score", 32'(rsp_score), 32'd0);
        check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        reset = 1'b0;

        // All requesters busy: grants must rotate 0,1,2,3,0,1,2,3.
        pend = '1;
        for (int j = 0; j < 8; j++) do_job($urandom_range(0, 6), 1'b0, 0, 1'b1);

        // Single job from requester 2, result four cycles into RUN.
        pend = 4'b0100;
        do_job(4, 1'b0, 0, 1'b0);
        // Timeout, coincident valid/expiry, and the neighbours of the boundary.
        do_job(1000, 1'b0, 0, 1'b0);
        do_job(TO - 1, 1'b0, 0, 1'b0);
        do_job(TO - 2, 1'b0, 0, 1'b0);
        do_job(TO, 1'b0, 0, 1'b0);
        // Bogus valid while the grid is being cleared.
        do_job(0, 1'b1, 0, 1'b0);
        do_job(3, 1'b1, 0, 1'b0);
        // Long response backpressure.
        do_job(5, 1'b0, 20, 1'b0);

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    #1;
                    check_eq("idle_ready", 32'(req_ready), 32'd0);
                    check_eq("idle_busy_gap", 32'(busy), 32'd0);
                end
            end
            kk = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, TO + 2);
            do_job(kk, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of RUN drops the job.
        pend = '1;
        gk = 1000;
        glitch = 1'b0;
        drive_reqs();
        #1;
        check_eq("pre_rst_grant", 32'(req_ready), 32'd1 << rr_m);
        for (int c = 0; c < 6; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_grid_reset", 32'(grid_reset), 32'd1);
        check_eq("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("postrst_rr", 32'(req_ready), 32'd1);
        req_valid = '0;
        stale = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        check_eq("stale_rsp", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
